// File: rtl/rac_pkg.sv
// Shared definitions for the register-access arbiter: register-bank widths and FSM state encoding.
package rac_pkg;

  localparam int RAC_REG_AW    = 7;
  localparam int RAC_REG_DW    = 8;
  localparam int RAC_REG_CRC_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT,
    ACK
  } rac_arb_st_e;

endpackage

// File: rtl/crc16to8_parallel.sv
// CRC-8 (poly 0x07, init 0x00, MSB first) over a 16-bit frame, fully combinational.
module crc16to8_parallel (
  input  logic [15:0] i_data,
  output logic [7:0]  o_crc
);

  function automatic logic [7:0] crc8_of(input logic [15:0] data);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ data[i]) ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction

  assign o_crc = crc8_of(i_data);

endmodule

// File: rtl/rac_arb.sv
// Round-robin register-access arbiter for two requesters: one bank strobe per grant, write CRC
// check, and a one-cycle ack with read data/address back to the served requester.
module rac_arb
  import rac_pkg::*;
#(
  parameter int REG_AW    = RAC_REG_AW,
  parameter int REG_DW    = RAC_REG_DW,
  parameter int REG_CRC_W = RAC_REG_CRC_W,
  parameter int RD_LAT    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_wr,
  input  logic [1:0]           i_req_rd,
  input  logic [REG_AW-1:0]    i_req_addr  [2],
  input  logic [REG_DW-1:0]    i_req_wdata [2],
  input  logic [REG_CRC_W-1:0] i_req_wcrc  [2],
  output logic [1:0]           o_wack,
  output logic [1:0]           o_rack,
  output logic [REG_DW-1:0]    o_rsp_data,
  output logic [REG_AW-1:0]    o_rsp_addr,
  output logic                 o_reg_wen,
  output logic                 o_reg_ren,
  output logic [REG_AW-1:0]    o_reg_addr,
  output logic [REG_DW-1:0]    o_reg_wdata,
  input  logic [REG_DW-1:0]    i_reg_rdata,
  output logic                 o_wcrc_err
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  rac_arb_st_e state, state_next;

  logic [1:0]              pend;
  logic                    sel;
  logic                    sel_wr;
  logic                    crc_ok;
  logic [REG_AW+REG_DW:0]  frame;
  logic [REG_CRC_W-1:0]    crc_calc;

  logic                    idx;
  logic                    is_wr;
  logic                    last;
  logic [1:0]              lat_cnt;

  logic                    grant;
  logic                    capture;
  logic                    wen_d, ren_d, err_d;
  logic [1:0]              wack_d, rack_d;

  assign pend = i_req_wr | i_req_rd;

  // Tie goes to the requester not granted last; otherwise the lone pending one wins.
  always_comb begin
    sel = 1'b0;
    if (pend == 2'b11) sel = ~last;
    else if (pend == 2'b10) sel = 1'b1;
  end

  assign sel_wr = i_req_wr[sel];
  assign frame  = {1'b1, i_req_addr[sel], i_req_wdata[sel]};

  crc16to8_parallel u_crc (
    .i_data (frame),
    .o_crc  (crc_calc)
  );

  // The CRC verdict is taken on the request being granted so the ISSUE strobes come straight from flops.
  assign crc_ok = (crc_calc == i_req_wcrc[sel]);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_next = state;
    grant      = 1'b0;
    capture    = 1'b0;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    err_d      = 1'b0;
    wack_d     = 2'b00;
    rack_d     = 2'b00;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          grant      = 1'b1;
          wen_d      = sel_wr & crc_ok;
          err_d      = sel_wr & ~crc_ok;
          ren_d      = ~sel_wr;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (is_wr) begin
          wack_d     = idx ? 2'b10 : 2'b01;
          state_next = ACK;
        end else begin
          state_next = RWAIT;
        end
      end
      RWAIT: begin
        if (lat_cnt == 2'd0) begin
          capture    = 1'b1;
          rack_d     = idx ? 2'b10 : 2'b01;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx         <= 1'b0;
      is_wr       <= 1'b0;
      last        <= 1'b1;
      lat_cnt     <= 2'd0;
      o_wack      <= 2'b00;
      o_rack      <= 2'b00;
      o_reg_wen   <= 1'b0;
      o_reg_ren   <= 1'b0;
      o_wcrc_err  <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_addr  <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
    end else begin
      o_wack     <= wack_d;
      o_rack     <= rack_d;
      o_reg_wen  <= wen_d;
      o_reg_ren  <= ren_d;
      o_wcrc_err <= err_d;

      if (grant) begin
        idx         <= sel;
        is_wr       <= sel_wr;
        o_reg_addr  <= i_req_addr[sel];
        o_reg_wdata <= i_req_wdata[sel];
      end

      if (state == ISSUE)      lat_cnt <= LAT_LOAD;
      else if (state == RWAIT) lat_cnt <= lat_cnt - 2'd1;

      if (capture)               o_rsp_data <= i_reg_rdata;
      if (|(wack_d | rack_d))    o_rsp_addr <= o_reg_addr;
      if (state == ACK)          last       <= idx;
    end
  end

endmodule

// File: tb/tb_rac_arb.sv
// Directed self-checking bench for rac_arb with RD_LAT=3 and a simple register-bank model.
module tb_rac_arb;

  localparam int RD_LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_wr, req_rd;
  logic [6:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic [7:0] req_wcrc  [2];
  logic [1:0] wack, rack;
  logic [7:0] rsp_data;
  logic [6:0] rsp_addr;
  logic       reg_wen, reg_ren, wcrc_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rac_arb #(.RD_LAT(RD_LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_wr    (req_wr),
    .i_req_rd    (req_rd),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_wcrc  (req_wcrc),
    .o_wack      (wack),
    .o_rack      (rack),
    .o_rsp_data  (rsp_data),
    .o_rsp_addr  (rsp_addr),
    .o_reg_wen   (reg_wen),
    .o_reg_ren   (reg_ren),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .i_reg_rdata (reg_rdata),
    .o_wcrc_err  (wcrc_err)
  );

  // Bank model: read data equals {0,addr}^0x39, valid only RD_LAT cycles after the ren cycle.
  logic [RD_LAT-1:0] ren_pipe = '0;
  always @(posedge clk) ren_pipe <= {ren_pipe[RD_LAT-2:0], reg_ren};
  assign reg_rdata = ren_pipe[RD_LAT-1] ? ({1'b0, reg_addr} ^ 8'h39) : 8'hEE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [7:0] crc8_ref(input logic [15:0] f);
    logic [7:0] c;
    logic [7:0] bytes [2];
    bytes[0] = f[15:8];
    bytes[1] = f[7:0];
    c = 8'h00;
    for (int b = 0; b < 2; b++) begin
      c = c ^ bytes[b];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_wack"},  wack, 0);
    check({tag, "_rack"},  rack, 0);
    check({tag, "_wen"},   reg_wen, 0);
    check({tag, "_ren"},   reg_ren, 0);
    check({tag, "_err"},   wcrc_err, 0);
    check({tag, "_rdata"}, rsp_data, 0);
    check({tag, "_raddr"}, rsp_addr, 0);
    check({tag, "_baddr"}, reg_addr, 0);
    check({tag, "_bwdat"}, reg_wdata, 0);
  endtask

  // Advances until an ack appears (bounded); lat counts cycles from the call, ren_at is the ren cycle.
  task automatic wait_ack(output int lat, output int ren_at);
    lat = 0;
    ren_at = 0;
    do begin
      cyc();
      lat++;
      if (reg_ren && ren_at == 0) ren_at = lat;
    end while (wack == 2'b00 && rack == 2'b00 && lat < 40);
  endtask

  initial begin
    int lat, ren_at;
    logic [6:0] exp_addr;

    rst = 1'b1;
    req_wr = 2'b00;
    req_rd = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0;
      req_wdata[i] = '0;
      req_wcrc[i] = '0;
    end
    repeat (3) cyc();
    check_all_zero("reset");
    rst = 1'b0;
    cyc();

    // Single write from requester 0; CRC of 16'h92A5 hand-computed as 0xB9.
    req_wr[0] = 1'b1; req_addr[0] = 7'h12; req_wdata[0] = 8'hA5; req_wcrc[0] = 8'hB9;
    cyc();
    check("wr_wen",   reg_wen, 1);
    check("wr_addr",  reg_addr, 7'h12);
    check("wr_wdata", reg_wdata, 8'hA5);
    check("wr_err",   wcrc_err, 0);
    check("wr_early", wack, 2'b00);
    cyc();
    check("wr_wack",  wack, 2'b01);
    check("wr_wen2",  reg_wen, 0);
    check("wr_raddr", rsp_addr, 7'h12);
    req_wr[0] = 1'b0;
    cyc();
    check("wr_wack_1cyc", wack, 2'b00);

    // Bad CRC from requester 1.
    req_wr[1] = 1'b1; req_addr[1] = 7'h12; req_wdata[1] = 8'hA5; req_wcrc[1] = 8'hB9 ^ 8'h01;
    cyc();
    check("bad_wen", reg_wen, 0);
    check("bad_err", wcrc_err, 1);
    cyc();
    check("bad_wack", wack, 2'b10);
    check("bad_err2", wcrc_err, 0);
    req_wr[1] = 1'b0;
    cyc();

    // Read latency with RD_LAT=3.
    req_rd[0] = 1'b1; req_addr[0] = 7'h05;
    wait_ack(lat, ren_at);
    check("rd_ren_at", ren_at, 1);
    check("rd_lat",    lat, 5);
    check("rd_rack",   rack, 2'b01);
    check("rd_data",   rsp_data, 8'h3C);
    check("rd_addr",   rsp_addr, 7'h05);
    req_rd[0] = 1'b0;
    cyc();

    // Round-robin from reset, both requesters reading continuously.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_addr[0] = 7'h21; req_addr[1] = 7'h42;
    req_rd = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_addr = (g % 2 == 1) ? 7'h42 : 7'h21;
      wait_ack(lat, ren_at);
      check($sformatf("rr_rack%0d", g), rack, (g % 2 == 1) ? 2'b10 : 2'b01);
      check($sformatf("rr_lat%0d", g),  lat, (g == 0) ? 5 : 6);
      check($sformatf("rr_addr%0d", g), rsp_addr, exp_addr);
      check($sformatf("rr_data%0d", g), rsp_data, {1'b0, exp_addr} ^ 8'h39);
    end
    req_rd = 2'b00;
    cyc();

    // Write takes priority over a simultaneous read from the same requester.
    req_wr[0] = 1'b1; req_rd[0] = 1'b1;
    req_addr[0] = 7'h33; req_wdata[0] = 8'h5A;
    req_wcrc[0] = crc8_ref({1'b1, 7'h33, 8'h5A});
    wait_ack(lat, ren_at);
    check("pri_first_wack", wack, 2'b01);
    check("pri_first_rack", rack, 2'b00);
    check("pri_first_lat",  lat, 2);
    req_wr[0] = 1'b0;
    wait_ack(lat, ren_at);
    check("pri_second_rack", rack, 2'b01);
    check("pri_second_lat",  lat, 6);
    check("pri_second_data", rsp_data, 8'h0A);
    req_rd[0] = 1'b0;
    cyc();

    // Reset during RWAIT with the request held.
    req_rd[0] = 1'b1; req_addr[0] = 7'h07;
    cyc();
    check("rst_ren", reg_ren, 1);
    cyc();
    rst = 1'b1;
    cyc();
    check_all_zero("midrst");
    rst = 1'b0;
    wait_ack(lat, ren_at);
    check("rst_lat",  lat, 5);
    check("rst_rack", rack, 2'b01);
    check("rst_data", rsp_data, 8'h3E);
    check("rst_addr", rsp_addr, 7'h07);
    req_rd[0] = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
